// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage hazard, forwarding and multiply-scoreboard controller
// Optional stall-cycle performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_scoreboard #(
    parameter int NSRC    = 2,
    parameter int RA_W    = 5,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [NSRC*RA_W-1:0] id_rs,
    input  logic [NSRC-1:0]      id_rs_used,
    input  logic [RA_W-1:0]      id_rd,
    input  logic                 id_regwrite,
    input  logic                 id_is_mul,
    input  logic                 id_pred_kill,
    input  logic                 flush,
    input  logic [RA_W-1:0]      ex_rd,
    input  logic [RA_W-1:0]      mem_rd,
    input  logic [RA_W-1:0]      wb_rd,
    input  logic                 ex_regwrite,
    input  logic                 mem_regwrite,
    input  logic                 wb_regwrite,
    input  logic                 ex_kill,
    input  logic                 mem_kill,
    input  logic                 wb_kill,
    input  logic                 ex_memread,
    output logic                 id_fire,
    output logic                 stall,
    output logic [NSRC*3-1:0]    fwd_sel,
    output logic                 mul_done,
    output logic [RA_W-1:0]      mul_done_rd,
    output logic [CNT_W-1:0]     perf_lu,
    output logic [CNT_W-1:0]     perf_sb,
    output logic [CNT_W-1:0]     perf_st
);

    localparam int NREG  = 2 ** RA_W;
    localparam int LAT_W = $clog2(MUL_LAT + 1);

    localparam logic [2:0] FWD_RF  = 3'b000;
    localparam logic [2:0] FWD_EX  = 3'b001;
    localparam logic [2:0] FWD_MEM = 3'b010;
    localparam logic [2:0] FWD_WB  = 3'b011;
    localparam logic [2:0] FWD_MUL = 3'b100;

    logic [NREG-1:0]  pend_q, pend_d;
    logic             busy_q, busy_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [RA_W-1:0]  mul_rd_q, mul_rd_d;
    logic             mul_done_q, mul_done_d;
    logic [RA_W-1:0]  mul_done_rd_q, mul_done_rd_d;

    logic ex_live, mem_live, wb_live;
    logic check_en, waw, cause_lu, cause_sb, cause_st;
    logic mul_issue, mul_complete;
    logic [NSRC-1:0] src_lu, src_sb;

    assign ex_live  = ex_regwrite  && !ex_kill  && (ex_rd  != '0);
    assign mem_live = mem_regwrite && !mem_kill && (mem_rd != '0);
    assign wb_live  = wb_regwrite  && !wb_kill  && (wb_rd  != '0);

    genvar k;
    generate
        for (k = 0; k < NSRC; k++) begin : g_src
            logic [RA_W-1:0] rs;
            logic            mul_hit;
            logic [2:0]      sel;

            assign rs      = id_rs[k*RA_W +: RA_W];
            assign mul_hit = mul_done_q && (mul_done_rd_q == rs) && (rs != '0);

            // Youngest producer wins; the mul bypass outranks the pipeline stages.
            assign sel = mul_hit                      ? FWD_MUL :
                         (ex_live  && ex_rd  == rs)   ? FWD_EX  :
                         (mem_live && mem_rd == rs)   ? FWD_MEM :
                         (wb_live  && wb_rd  == rs)   ? FWD_WB  : FWD_RF;
            assign fwd_sel[k*3 +: 3] = sel;

            assign src_lu[k] = id_rs_used[k] && ex_live && ex_memread && (ex_rd == rs);
            assign src_sb[k] = id_rs_used[k] && pend_q[rs]
                               && !(mul_done_q && mul_done_rd_q == rs);
        end
    endgenerate

    assign check_en = id_valid && !flush && rst_n;
    assign waw      = id_regwrite && !id_pred_kill && pend_q[id_rd] && (id_rd != '0);
    assign cause_lu = check_en && (|src_lu);
    assign cause_sb = check_en && ((|src_sb) || waw);
    // A new mul may enter in the last busy cycle, handing the unit over seamlessly.
    assign cause_st = check_en && id_is_mul && !id_pred_kill && busy_q
                      && (cnt_q != LAT_W'(1));

    assign stall   = cause_lu || cause_sb || cause_st;
    assign id_fire = check_en && !stall;

    assign mul_issue    = id_fire && id_is_mul && !id_pred_kill;
    assign mul_complete = busy_q && (cnt_q == LAT_W'(1));

    always_comb begin
        pend_d        = pend_q;
        busy_d        = busy_q;
        cnt_d         = cnt_q;
        mul_rd_d      = mul_rd_q;
        mul_done_d    = 1'b0;
        mul_done_rd_d = mul_done_rd_q;

        if (mul_complete) begin
            mul_done_d       = 1'b1;
            mul_done_rd_d    = mul_rd_q;
            pend_d[mul_rd_q] = 1'b0;
            busy_d           = 1'b0;
            cnt_d            = '0;
        end else if (busy_q && cnt_q > LAT_W'(1)) begin
            cnt_d = cnt_q - LAT_W'(1);
        end

        // Issue is applied after the clear so a same-register set wins.
        if (mul_issue) begin
            busy_d        = 1'b1;
            cnt_d         = LAT_W'(MUL_LAT);
            mul_rd_d      = id_rd;
            pend_d[id_rd] = 1'b1;
        end

        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q        <= '0;
            busy_q        <= 1'b0;
            cnt_q         <= '0;
            mul_rd_q      <= '0;
            mul_done_q    <= 1'b0;
            mul_done_rd_q <= '0;
        end else begin
            pend_q        <= pend_d;
            busy_q        <= busy_d;
            cnt_q         <= cnt_d;
            mul_rd_q      <= mul_rd_d;
            mul_done_q    <= mul_done_d;
            mul_done_rd_q <= mul_done_rd_d;
        end
    end

    assign mul_done    = mul_done_q;
    assign mul_done_rd = mul_done_rd_q;

`ifdef HAZ_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] perf_lu_q, perf_lu_d;
    logic [CNT_W-1:0] perf_sb_q, perf_sb_d;
    logic [CNT_W-1:0] perf_st_q, perf_st_d;

    always_comb begin
        perf_lu_d = perf_lu_q;
        perf_sb_d = perf_sb_q;
        perf_st_d = perf_st_q;
        if (cause_lu && perf_lu_q != CNT_MAX) perf_lu_d = perf_lu_q + CNT_W'(1);
        if (cause_sb && perf_sb_q != CNT_MAX) perf_sb_d = perf_sb_q + CNT_W'(1);
        if (cause_st && perf_st_q != CNT_MAX) perf_st_d = perf_st_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_lu_q <= '0;
            perf_sb_q <= '0;
            perf_st_q <= '0;
        end else begin
            perf_lu_q <= perf_lu_d;
            perf_sb_q <= perf_sb_d;
            perf_st_q <= perf_st_d;
        end
    end

    assign perf_lu = perf_lu_q;
    assign perf_sb = perf_sb_q;
    assign perf_st = perf_st_q;
`else
    assign perf_lu = '0;
    assign perf_sb = '0;
    assign perf_st = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed vector bench for hazard_scoreboard
module tb_hazard_scoreboard;

`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, flush, id_regwrite, id_is_mul, id_pred_kill;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [4:0]  id_rd, ex_rd, mem_rd, wb_rd;
    logic        ex_regwrite, mem_regwrite, wb_regwrite;
    logic        ex_kill, mem_kill, wb_kill, ex_memread;
    logic        id_fire, stall, mul_done;
    logic [5:0]  fwd_sel;
    logic [4:0]  mul_done_rd;
    logic [15:0] perf_lu, perf_sb, perf_st;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_is_mul(id_is_mul), .id_pred_kill(id_pred_kill), .flush(flush),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .ex_kill(ex_kill), .mem_kill(mem_kill), .wb_kill(wb_kill),
        .ex_memread(ex_memread), .id_fire(id_fire), .stall(stall), .fwd_sel(fwd_sel),
        .mul_done(mul_done), .mul_done_rd(mul_done_rd),
        .perf_lu(perf_lu), .perf_sb(perf_sb), .perf_st(perf_st)
    );

    typedef struct {
        logic       valid;
        logic       flush;
        logic [9:0] rs;
        logic [1:0] used;
        logic [4:0] ex_rd;
        logic       ex_rw;
        logic       ex_kill;
        logic       memread;
        logic [4:0] mem_rd;
        logic       mem_rw;
        logic       mem_kill;
        logic [4:0] wb_rd;
        logic       wb_rw;
        logic       wb_kill;
        logic [5:0] fwd;
        logic       stall;
        logic       fire;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle();
        id_valid = 1'b0; flush = 1'b0; id_rs = '0; id_rs_used = '0; id_rd = '0;
        id_regwrite = 1'b0; id_is_mul = 1'b0; id_pred_kill = 1'b0;
        ex_rd = '0; mem_rd = '0; wb_rd = '0;
        ex_regwrite = 1'b0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
        ex_kill = 1'b0; mem_kill = 1'b0; wb_kill = 1'b0; ex_memread = 1'b0;
    endtask

    task automatic present_mul(input logic [4:0] rd);
        idle();
        id_valid = 1'b1; id_is_mul = 1'b1; id_rd = rd;
    endtask

    task automatic present_consumer(input logic [4:0] rs);
        idle();
        id_valid = 1'b1; id_rs = {5'd0, rs}; id_rs_used = 2'b01;
        id_rd = 5'd10; id_regwrite = 1'b1;
    endtask

    // Holds reset for one edge with a load-use hazard presented, then releases it.
    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        id_valid = 1'b1; id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
        ex_rd = 5'd7; ex_regwrite = 1'b1; ex_memread = 1'b1;
        settle();
        chk("rst_stall", stall, 0);
        chk("rst_fire", id_fire, 0);
        next_cycle();
        rst_n = 1'b1;
        idle();
        settle();
        chk("rst_mul_done", mul_done, 0);
        chk("rst_mul_done_rd", mul_done_rd, 0);
        chk("rst_perf_lu", perf_lu, 0);
        chk("rst_perf_sb", perf_sb, 0);
        chk("rst_perf_st", perf_st, 0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, {5'd5, 5'd5}, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0,
                    5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 6'b001_001, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, {5'd5, 5'd5}, 2'b11, 5'd5, 1'b1, 1'b1, 1'b0,
                    5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 6'b010_010, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, {5'd5, 5'd5}, 2'b11, 5'd5, 1'b1, 1'b1, 1'b0,
                    5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 6'b011_011, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, {5'd5, 5'd5}, 2'b11, 5'd5, 1'b1, 1'b1, 1'b0,
                    5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 6'b000_000, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, {5'd3, 5'd7}, 2'b11, 5'd7, 1'b1, 1'b0, 1'b1,
                    5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000_001, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, {5'd3, 5'd7}, 2'b10, 5'd7, 1'b1, 1'b0, 1'b1,
                    5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000_001, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, {5'd7, 5'd3}, 2'b11, 5'd7, 1'b1, 1'b0, 1'b1,
                    5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b001_000, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, {5'd0, 5'd0}, 2'b11, 5'd0, 1'b1, 1'b0, 1'b1,
                    5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 6'b000_000, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, {5'd8, 5'd6}, 2'b11, 5'd4, 1'b1, 1'b0, 1'b0,
                    5'd6, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 6'b011_010, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, {5'd3, 5'd7}, 2'b11, 5'd7, 1'b1, 1'b0, 1'b1,
                    5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000_001, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, {5'd3, 5'd7}, 2'b11, 5'd7, 1'b1, 1'b0, 1'b1,
                    5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000_001, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, {5'd3, 5'd7}, 2'b11, 5'd7, 1'b1, 1'b1, 1'b1,
                    5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000_010, 1'b0, 1'b1};

        idle();
        rst_n = 1'b0;
        next_cycle();
        do_reset();

        // Single-cycle forwarding and load-use vectors.
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            idle();
            id_valid = tbl[i].valid; flush = tbl[i].flush;
            id_rs = tbl[i].rs; id_rs_used = tbl[i].used;
            ex_rd = tbl[i].ex_rd; ex_regwrite = tbl[i].ex_rw; ex_kill = tbl[i].ex_kill;
            ex_memread = tbl[i].memread;
            mem_rd = tbl[i].mem_rd; mem_regwrite = tbl[i].mem_rw; mem_kill = tbl[i].mem_kill;
            wb_rd = tbl[i].wb_rd; wb_regwrite = tbl[i].wb_rw; wb_kill = tbl[i].wb_kill;
            settle();
            chk($sformatf("vec%0d_fwd", i), fwd_sel, tbl[i].fwd);
            chk($sformatf("vec%0d_stall", i), stall, tbl[i].stall);
            chk($sformatf("vec%0d_fire", i), id_fire, tbl[i].fire);
        end
        next_cycle();
        idle();
        settle();
        chk("tbl_perf_lu", perf_lu, PERF ? 2 : 0);
        chk("tbl_perf_sb", perf_sb, 0);

        // Mul RAW: consumer of r9 stalls t+1..t+4, bypasses at t+5.
        do_reset();
        next_cycle();
        present_mul(5'd9);
        settle();
        chk("raw_mul_fire", id_fire, 1);
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            present_consumer(5'd9);
            settle();
            chk($sformatf("raw_stall_t%0d", c), stall, 1);
            chk($sformatf("raw_nofire_t%0d", c), id_fire, 0);
            chk($sformatf("raw_nodone_t%0d", c), mul_done, 0);
        end
        next_cycle();
        settle();
        chk("raw_done", mul_done, 1);
        chk("raw_done_rd", mul_done_rd, 9);
        chk("raw_fwd_mul", fwd_sel[2:0], 3'b100);
        chk("raw_stall_t5", stall, 0);
        chk("raw_fire_t5", id_fire, 1);
        chk("raw_perf_sb", perf_sb, PERF ? 4 : 0);
        next_cycle();
        idle();
        settle();
        chk("raw_done_pulse", mul_done, 0);

        // Back-to-back muls to r9.
        do_reset();
        next_cycle();
        present_mul(5'd9);
        settle();
        chk("b2b_first_fire", id_fire, 1);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            present_mul(5'd9);
            settle();
            chk($sformatf("b2b_st_stall_t%0d", c), stall, 1);
        end
        next_cycle();
        present_mul(5'd9);
        settle();
        chk("b2b_second_fire_t4", id_fire, 1);
        chk("b2b_perf_st", perf_st, PERF ? 3 : 0);
        next_cycle();
        idle();
        settle();
        chk("b2b_first_done_t5", mul_done, 1);
        for (int c = 6; c <= 8; c++) begin
            next_cycle();
            present_consumer(5'd9);
            settle();
            chk($sformatf("b2b_pend_stall_t%0d", c), stall, 1);
            chk($sformatf("b2b_nodone_t%0d", c), mul_done, 0);
        end
        next_cycle();
        settle();
        chk("b2b_second_done_t9", mul_done, 1);
        chk("b2b_second_rd_t9", mul_done_rd, 9);
        chk("b2b_fwd_t9", fwd_sel[2:0], 3'b100);
        chk("b2b_fire_t9", id_fire, 1);
        chk("b2b_perf_sb", perf_sb, PERF ? 3 : 0);

        // Flush during a scoreboard stall, then reset mid-multiply.
        do_reset();
        next_cycle();
        present_mul(5'd9);
        settle();
        chk("fl_mul_fire", id_fire, 1);
        next_cycle();
        present_consumer(5'd9);
        settle();
        chk("fl_stall_before", stall, 1);
        next_cycle();
        present_consumer(5'd9);
        flush = 1'b1;
        settle();
        chk("fl_flush_stall", stall, 0);
        chk("fl_flush_fire", id_fire, 0);
        next_cycle();
        present_consumer(5'd9);
        settle();
        chk("fl_pend_kept", stall, 1);
        next_cycle();
        present_consumer(5'd9);
        rst_n = 1'b0;
        settle();
        chk("fl_rst_stall", stall, 0);
        chk("fl_rst_fire", id_fire, 0);
        next_cycle();
        rst_n = 1'b1;
        settle();
        chk("fl_after_rst_stall", stall, 0);
        chk("fl_after_rst_fire", id_fire, 1);
        chk("fl_after_rst_fwd", fwd_sel, 0);
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            idle();
            settle();
            chk($sformatf("fl_no_done_%0d", c), mul_done, 0);
        end

        // Register zero: no pend bit, no stall, no mul bypass.
        do_reset();
        next_cycle();
        present_mul(5'd0);
        settle();
        chk("r0_mul_fire", id_fire, 1);
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            present_consumer(5'd0);
            settle();
            chk($sformatf("r0_nostall_t%0d", c), stall, 0);
        end
        next_cycle();
        present_consumer(5'd0);
        settle();
        chk("r0_done_t5", mul_done, 1);
        chk("r0_fwd_t5", fwd_sel, 0);
        chk("r0_fire_t5", id_fire, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
